// File: rtl/sample_history_buffer.sv
// sample_history_buffer: circular history of the newest DEPTH samples, read back by lag.
// Reads are registered, take one cycle, and see the array as it was before any push in
// the same cycle. Fill level and full are tracked, and reads beyond the stored history
// are flagged as out of range.
// Optional macro SAMPLE_HISTORY_ZERO_PAD_EN: out-of-range reads return zero data.
module sample_history_buffer #(
    parameter int unsigned BITS         = 16,
    parameter int unsigned DEPTH        = 16,
    parameter int unsigned ADDRESS_BITS = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    clear,
    input  logic                    in_valid,
    input  logic [BITS-1:0]         in_data,
    input  logic                    rd_req,
    input  logic [ADDRESS_BITS-1:0] rd_lag,
    output logic                    rd_valid,
    output logic [BITS-1:0]         rd_data,
    output logic                    rd_oob,
    output logic [ADDRESS_BITS:0]   fill,
    output logic                    full
);

    localparam int unsigned FILL_W = ADDRESS_BITS + 1;
    localparam logic [FILL_W-1:0] DEPTH_FILL = FILL_W'(DEPTH);

    logic [BITS-1:0]         mem_q [DEPTH];
    logic [ADDRESS_BITS-1:0] wr_ptr_q, wr_ptr_d;
    logic [FILL_W-1:0]       fill_q, fill_d;
    logic                    full_q, full_d;
    logic                    rd_valid_q, rd_valid_d;
    logic [BITS-1:0]         rd_data_q, rd_data_d;
    logic                    rd_oob_q, rd_oob_d;

    logic [ADDRESS_BITS-1:0] rd_addr_c;
    logic                    rd_oob_c;
    logic                    push_c;

    // Address of the requested sample; wraps naturally because DEPTH is a power of two.
    assign rd_addr_c = wr_ptr_q - ADDRESS_BITS'(1) - rd_lag;
    assign rd_oob_c  = ({1'b0, rd_lag} >= fill_q);
    assign push_c    = in_valid && !clear;

    // Next state of the pointer, fill level and read result.
    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        fill_d     = fill_q;
        rd_valid_d = 1'b0;
        rd_data_d  = rd_data_q;
        rd_oob_d   = rd_oob_q;
        if (clear) begin
            wr_ptr_d = '0;
            fill_d   = '0;
        end else begin
            if (in_valid) begin
                wr_ptr_d = wr_ptr_q + ADDRESS_BITS'(1);
                if (fill_q != DEPTH_FILL) begin
                    fill_d = fill_q + FILL_W'(1);
                end
            end
            if (rd_req) begin
                rd_valid_d = 1'b1;
                rd_oob_d   = rd_oob_c;
`ifdef SAMPLE_HISTORY_ZERO_PAD_EN
                rd_data_d  = rd_oob_c ? '0 : mem_q[rd_addr_c];
`else
                rd_data_d  = mem_q[rd_addr_c];
`endif
            end
        end
        full_d = (fill_d == DEPTH_FILL);
    end

    // Pointer, fill and read-result registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q   <= '0;
            fill_q     <= '0;
            full_q     <= 1'b0;
            rd_valid_q <= 1'b0;
            rd_data_q  <= '0;
            rd_oob_q   <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            fill_q     <= fill_d;
            full_q     <= full_d;
            rd_valid_q <= rd_valid_d;
            rd_data_q  <= rd_data_d;
            rd_oob_q   <= rd_oob_d;
        end
    end

    // Sample storage; cleared only by reset, never by the clear strobe.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (push_c) begin
            mem_q[wr_ptr_q] <= in_data;
        end
    end

    assign rd_valid = rd_valid_q;
    assign rd_data  = rd_data_q;
    assign rd_oob   = rd_oob_q;
    assign fill     = fill_q;
    assign full     = full_q;

endmodule

// File: tb/tb_sample_history_buffer.sv
// Bench for sample_history_buffer: reference model plus a scoreboard queue of expected reads.
module tb_sample_history_buffer;

    localparam int unsigned BITS  = 16;
    localparam int unsigned DEPTH = 16;
    localparam int unsigned AW    = 4;
`ifdef SAMPLE_HISTORY_ZERO_PAD_EN
    localparam bit ZERO_PAD = 1'b1;
`else
    localparam bit ZERO_PAD = 1'b0;
`endif

    logic            clk = 1'b0;
    logic            rst;
    logic            clear;
    logic            in_valid;
    logic [BITS-1:0] in_data;
    logic            rd_req;
    logic [AW-1:0]   rd_lag;
    logic            rd_valid;
    logic [BITS-1:0] rd_data;
    logic            rd_oob;
    logic [AW:0]     fill;
    logic            full;

    always #5 clk = ~clk;

    sample_history_buffer #(.BITS(BITS), .DEPTH(DEPTH), .ADDRESS_BITS(AW)) dut (
        .clk      (clk),
        .rst      (rst),
        .clear    (clear),
        .in_valid (in_valid),
        .in_data  (in_data),
        .rd_req   (rd_req),
        .rd_lag   (rd_lag),
        .rd_valid (rd_valid),
        .rd_data  (rd_data),
        .rd_oob   (rd_oob),
        .fill     (fill),
        .full     (full)
    );

    typedef struct packed {
        logic [BITS-1:0] data;
        logic            oob;
    } exp_t;

    exp_t sb_q[$];
    int   checks = 0;
    int   errors = 0;

    // Reference model state.
    logic [BITS-1:0] m_mem [DEPTH];
    logic [AW-1:0]   m_wp;
    logic [AW:0]     m_fill;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < int'(DEPTH); i++) m_mem[i] = '0;
        m_wp   = '0;
        m_fill = '0;
        sb_q.delete();
    endtask

    task automatic apply_reset();
        rst      = 1'b0;
        clear    = 1'b0;
        in_valid = 1'b0;
        in_data  = '0;
        rd_req   = 1'b0;
        rd_lag   = '0;
        model_reset();
        @(negedge clk);
        check("rst_rd_valid", 32'(rd_valid), 32'd0);
        check("rst_rd_data", 32'(rd_data), 32'd0);
        check("rst_rd_oob", 32'(rd_oob), 32'd0);
        check("rst_fill", 32'(fill), 32'd0);
        check("rst_full", 32'(full), 32'd0);
        @(negedge clk);
        rst = 1'b1;
    endtask

    // One clock: drive at the falling edge, predict, then check on the next falling edge.
    task automatic cycle(input logic clr, input logic iv, input logic [BITS-1:0] d,
                         input logic rq, input logic [AW-1:0] lag);
        exp_t          e;
        exp_t          got;
        logic [AW-1:0] addr;
        clear    = clr;
        in_valid = iv;
        in_data  = d;
        rd_req   = rq;
        rd_lag   = lag;
        if (rq && !clr) begin
            addr   = m_wp - AW'(1) - lag;
            e.oob  = ({1'b0, lag} >= m_fill);
            e.data = (e.oob && ZERO_PAD) ? '0 : m_mem[addr];
            sb_q.push_back(e);
        end
        @(posedge clk);
        if (clr) begin
            m_wp   = '0;
            m_fill = '0;
        end else if (iv) begin
            m_mem[m_wp] = d;
            m_wp        = m_wp + AW'(1);
            if (m_fill != (AW+1)'(DEPTH)) m_fill = m_fill + (AW+1)'(1);
        end
        @(negedge clk);
        check("fill", 32'(fill), 32'(m_fill));
        check("full", 32'(full), 32'(m_fill == (AW+1)'(DEPTH)));
        check("rd_valid", 32'(rd_valid), 32'(rq && !clr));
        if (rd_valid) begin
            if (sb_q.size() == 0) begin
                check("sb_unexpected", 32'd1, 32'd0);
            end else begin
                got = sb_q.pop_front();
                check("rd_data", 32'(rd_data), 32'(got.data));
                check("rd_oob", 32'(rd_oob), 32'(got.oob));
            end
        end
    endtask

    task automatic idle();
        cycle(1'b0, 1'b0, '0, 1'b0, '0);
    endtask

    initial begin
        apply_reset();

        // Push 1,2,3 then back-to-back reads of lags 0,1,2.
        for (int i = 1; i <= 3; i++) cycle(1'b0, 1'b1, BITS'(i), 1'b0, '0);
        cycle(1'b0, 1'b0, '0, 1'b1, AW'(0));
        check("t1_lag0", 32'(rd_data), 32'd3);
        cycle(1'b0, 1'b0, '0, 1'b1, AW'(1));
        check("t1_lag1", 32'(rd_data), 32'd2);
        cycle(1'b0, 1'b0, '0, 1'b1, AW'(2));
        check("t1_lag2", 32'(rd_data), 32'd1);
        idle();
        check("t1_hold", 32'(rd_data), 32'd1);

        // Overfill: push 1..20 into a 16-deep buffer.
        apply_reset();
        for (int i = 1; i <= 20; i++) cycle(1'b0, 1'b1, BITS'(i), 1'b0, '0);
        check("t2_full", 32'(full), 32'd1);
        check("t2_fill", 32'(fill), 32'd16);
        cycle(1'b0, 1'b0, '0, 1'b1, AW'(0));
        check("t2_lag0", 32'(rd_data), 32'd20);
        cycle(1'b0, 1'b0, '0, 1'b1, AW'(15));
        check("t2_lag15", 32'(rd_data), 32'd5);
        check("t2_oob15", 32'(rd_oob), 32'd0);

        // Same-cycle push and read: read sees the previous newest sample.
        cycle(1'b0, 1'b1, 16'h0055, 1'b0, '0);
        cycle(1'b0, 1'b1, 16'h00AA, 1'b1, AW'(0));
        check("t3_rbw", 32'(rd_data), 32'h55);
        cycle(1'b0, 1'b0, '0, 1'b1, AW'(0));
        check("t3_next", 32'(rd_data), 32'hAA);

        // Clear keeps array contents but resets pointer and fill.
        apply_reset();
        for (int i = 1; i <= 4; i++) cycle(1'b0, 1'b1, BITS'(i), 1'b0, '0);
        cycle(1'b1, 1'b0, '0, 1'b0, '0);
        cycle(1'b0, 1'b1, 16'd9, 1'b0, '0);
        cycle(1'b0, 1'b0, '0, 1'b1, AW'(1));
        check("t4_oob", 32'(rd_oob), 32'd1);
        check("t4_data", 32'(rd_data), 32'd0);
        cycle(1'b0, 1'b0, '0, 1'b1, AW'(0));
        check("t4_lag0", 32'(rd_data), 32'd9);

        // Clear together with push and read: both ignored.
        cycle(1'b1, 1'b1, 16'h1234, 1'b1, AW'(0));
        check("t6_fill", 32'(fill), 32'd0);
        cycle(1'b0, 1'b1, 16'h0777, 1'b0, '0);
        cycle(1'b0, 1'b0, '0, 1'b1, AW'(0));
        check("t6_ptr", 32'(rd_data), 32'h777);

        // Reset arriving while a read is pending discards it.
        rd_req = 1'b1;
        rd_lag = '0;
        #2 rst = 1'b0;
        model_reset();
        @(posedge clk);
        @(negedge clk);
        check("t5_rd_valid", 32'(rd_valid), 32'd0);
        check("t5_rd_data", 32'(rd_data), 32'd0);
        check("t5_rd_oob", 32'(rd_oob), 32'd0);
        check("t5_fill", 32'(fill), 32'd0);
        rd_req = 1'b0;
        rst    = 1'b1;
        idle();

        // Random traffic against the model.
        for (int n = 0; n < 400; n++) begin
            cycle(($urandom_range(0, 29) == 0), 1'($urandom_range(0, 1)),
                  BITS'($urandom), 1'($urandom_range(0, 1)), AW'($urandom_range(0, DEPTH-1)));
        end
        idle();
        check("sb_drained", 32'(sb_q.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
